// File: rtl/arb_requester_pkg.sv
// Shared types and default parameters for the arbiter client agent.
// Anything instantiating arb_requester imports this package.
package arb_requester_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StXfer = 2'd2,
        StGap  = 2'd3
    } state_e;

    localparam int unsigned LenWDefault      = 4;
    localparam int unsigned GapCycDefault    = 1;
    localparam int unsigned StarveCycDefault = 15;

endpackage

// File: rtl/arb_requester.sv
// Client-side agent for a two-port req/gnt arbiter: takes a job, requests the resource,
// drives one beat per granted cycle, then idles for a fixed gap before the next job.
module arb_requester
    import arb_requester_pkg::*;
#(
    parameter int unsigned LenW      = LenWDefault,
    parameter int unsigned GapCyc    = GapCycDefault,
    parameter int unsigned StarveCyc = StarveCycDefault
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            job_valid_i,
    input  logic [LenW-1:0] job_len_i,
    output logic            job_ready_o,
    output logic            req_o,
    input  logic            gnt_i,
    output logic            beat_valid_o,
    output logic            beat_last_o,
    output logic            done_o,
    output logic            abort_o,
    output logic            starve_o
);

    localparam int unsigned WaitW = $clog2(StarveCyc + 1);
    localparam int unsigned GapW  = (GapCyc > 1) ? $clog2(GapCyc) : 1;

    localparam logic [WaitW-1:0] StarveMax = WaitW'(StarveCyc);
    localparam logic [GapW-1:0]  GapLoad   = GapW'(GapCyc - 1);

    state_e            state_q;
    logic [LenW-1:0]   beat_cnt_q;
    logic [WaitW-1:0]  wait_cnt_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic              job_ready_q;
    logic              req_q;
    logic              beat_last_q;
    logic              done_q;
    logic              abort_q;
    logic              starve_q;

    logic [WaitW-1:0]  wait_cnt_d;
    logic [LenW-1:0]   beat_cnt_d;

    // Wait counter holds the index of the current REQ cycle and saturates at the threshold.
    always_comb begin
        wait_cnt_d = (wait_cnt_q == StarveMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
        beat_cnt_d = beat_cnt_q - LenW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            job_ready_q <= 1'b0;
            req_q       <= 1'b0;
            beat_last_q <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            starve_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    job_ready_q <= 1'b1;
                    if (job_ready_q && job_valid_i) begin
                        beat_cnt_q  <= (job_len_i == '0) ? LenW'(1) : job_len_i;
                        wait_cnt_q  <= WaitW'(1);
                        job_ready_q <= 1'b0;
                        req_q       <= 1'b1;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (gnt_i) begin
                        starve_q    <= 1'b0;
                        wait_cnt_q  <= '0;
                        beat_last_q <= (beat_cnt_q == LenW'(1));
                        state_q     <= StXfer;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_d == StarveMax) begin
                            starve_q <= 1'b1;
                        end
                    end
                end
                StXfer: begin
                    // beat_last_q doubles as "one beat remaining" while in XFER.
                    if (!gnt_i || beat_last_q) begin
                        abort_q     <= !gnt_i;
                        done_q      <= gnt_i;
                        req_q       <= 1'b0;
                        beat_last_q <= 1'b0;
                        gap_cnt_q   <= GapLoad;
                        state_q     <= StGap;
                    end else begin
                        beat_cnt_q  <= beat_cnt_d;
                        beat_last_q <= (beat_cnt_d == LenW'(1));
                    end
                end
                StGap: begin
                    if (gap_cnt_q == '0) begin
                        job_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign job_ready_o  = job_ready_q;
    assign req_o        = req_q;
    assign beat_valid_o = gnt_i && (state_q == StXfer);
    assign beat_last_o  = beat_last_q;
    assign done_o       = done_q;
    assign abort_o      = abort_q;
    assign starve_o     = starve_q;

endmodule

// File: tb/tb_arb_requester.sv
// Two requesters behind a registered fixed-priority arbiter, checked every cycle against
// a job-level model plus hand-computed timing expectations.
module tb_arb_requester;

    localparam int GapCyc    = 1;
    localparam int StarveCyc = 15;

    logic       clk_i;
    logic       rst_n;
    logic [1:0] jv;
    logic [3:0] jl [2];
    logic [1:0] ready, req, bv, last, done, abort, starve;
    logic       gnt0, gnt1, ag0, ag1, gf0, use_arb;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Job-level model state
    bit m_busy [2];
    bit m_gr   [2];
    int m_left [2];
    int m_gap  [2];
    int m_wait [2];
    bit e_ready [2], e_req [2], e_last [2], e_done [2], e_abort [2], e_starve [2];

    // Observed tallies
    int beats [2], last_idx [2], done_cnt [2], abort_cnt [2], done_cyc [2];
    int first_req [2], first_beat [2], first_starve [2], ready_rise [2];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    arb_requester u_req0 (
        .clk_i       (clk_i),
        .rst_ni      (rst_n),
        .job_valid_i (jv[0]),
        .job_len_i   (jl[0]),
        .job_ready_o (ready[0]),
        .req_o       (req[0]),
        .gnt_i       (gnt0),
        .beat_valid_o(bv[0]),
        .beat_last_o (last[0]),
        .done_o      (done[0]),
        .abort_o     (abort[0]),
        .starve_o    (starve[0])
    );

    arb_requester u_req1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_n),
        .job_valid_i (jv[1]),
        .job_len_i   (jl[1]),
        .job_ready_o (ready[1]),
        .req_o       (req[1]),
        .gnt_i       (gnt1),
        .beat_valid_o(bv[1]),
        .beat_last_o (last[1]),
        .done_o      (done[1]),
        .abort_o     (abort[1]),
        .starve_o    (starve[1])
    );

    // Registered arbiter, port 0 has priority; a grant is held while its req stays high.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ag0 <= 1'b0;
            ag1 <= 1'b0;
        end else if (ag0) begin
            ag0 <= req[0];
        end else if (ag1) begin
            ag1 <= req[1];
        end else if (req[0]) begin
            ag0 <= 1'b1;
        end else if (req[1]) begin
            ag1 <= 1'b1;
        end
    end

    assign gnt0 = use_arb ? ag0 : gf0;
    assign gnt1 = use_arb ? ag1 : 1'b0;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic model_reset(input int i);
        m_busy[i] = 0; m_gr[i] = 0; m_left[i] = 0; m_gap[i] = 0; m_wait[i] = 0;
        e_ready[i] = 0; e_req[i] = 0; e_last[i] = 0;
        e_done[i] = 0; e_abort[i] = 0; e_starve[i] = 0;
    endtask

    task automatic end_job(input int i);
        m_busy[i] = 0;
        m_gr[i]   = 0;
        m_gap[i]  = GapCyc;
    endtask

    // Runs at the falling edge: compare DUT to model, then advance the model with the
    // inputs that the next rising edge will sample.
    task automatic compare_cycle();
        cyc++;
        n_tests++;
        if (bv[0] && bv[1]) begin
            n_fail++;
            $display("FAIL overlap: cycle %0d both beat_valid=1, expected at most one", cyc);
        end
        for (int i = 0; i < 2; i++) begin
            logic       g;
            logic [6:0] act, expv;
            g = (i == 0) ? gnt0 : gnt1;
            if (!rst_n) model_reset(i);
            act  = {ready[i], req[i], bv[i], last[i], done[i], abort[i], starve[i]};
            expv = {e_ready[i], e_req[i], m_gr[i] & g, e_last[i],
                    e_done[i], e_abort[i], e_starve[i]};
            n_tests++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL outputs%0d cycle %0d: {rdy,req,bv,last,done,abort,starve} got %b expected %b",
                         i, cyc, act, expv);
            end
            if (req[i] && first_req[i] < 0) first_req[i] = cyc;
            if (bv[i]) begin
                beats[i]++;
                if (first_beat[i] < 0) first_beat[i] = cyc;
                if (last[i]) last_idx[i] = beats[i];
            end
            if (done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
            if (abort[i]) abort_cnt[i]++;
            if (starve[i] && first_starve[i] < 0) first_starve[i] = cyc;
            if (ready[i] && ready_rise[i] < 0 && first_req[i] >= 0) ready_rise[i] = cyc;

            if (rst_n) begin
                e_done[i]  = 0;
                e_abort[i] = 0;
                if (m_busy[i] && !m_gr[i]) begin
                    if (g) begin
                        m_gr[i]     = 1;
                        e_starve[i] = 0;
                    end else begin
                        m_wait[i]++;
                        if (m_wait[i] >= StarveCyc) e_starve[i] = 1;
                    end
                end else if (m_gr[i]) begin
                    if (!g) begin
                        e_abort[i] = 1;
                        end_job(i);
                    end else begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            e_done[i] = 1;
                            end_job(i);
                        end
                    end
                end else if (m_gap[i] > 0) begin
                    m_gap[i]--;
                end else if (e_ready[i] && jv[i]) begin
                    m_busy[i] = 1;
                    m_left[i] = (jl[i] == 0) ? 1 : int'(jl[i]);
                    m_wait[i] = 1;
                end
                e_req[i]   = m_busy[i];
                e_ready[i] = !m_busy[i] && (m_gap[i] == 0);
                e_last[i]  = m_gr[i] && (m_left[i] == 1);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        compare_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 2; i++) begin
            beats[i] = 0; last_idx[i] = 0; done_cnt[i] = 0; abort_cnt[i] = 0;
            done_cyc[i] = -1; first_req[i] = -1; first_beat[i] = -1;
            first_starve[i] = -1; ready_rise[i] = -1;
        end
    endtask

    task automatic wait_ready(input int i, input int budget);
        int n;
        n = 0;
        while (!ready[i] && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (!ready[i]) begin
            n_fail++;
            $display("FAIL timeout%0d: job_ready still 0 after %0d cycles, expected 1", i, budget);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n = 1'b0; jv = '0; jl[0] = '0; jl[1] = '0; gf0 = 1'b0; use_arb = 1'b1;
        for (int i = 0; i < 2; i++) model_reset(i);
        clear_tally();
        tick();
        tick();
        check("ready_in_reset", int'(ready[0]), 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_release", int'(ready[0]), 1);
        tick();

        // len=3 through idle arbiter
        clear_tally();
        jv[0] = 1'b1; jl[0] = 4'd3; acc = cyc + 1;
        tick();
        jv[0] = 1'b0;
        wait_ready(0, 30);
        check("len3_req_after_accept", first_req[0] - acc, 1);
        check("len3_first_beat", first_beat[0] - first_req[0], 2);
        check("len3_beats", beats[0], 3);
        check("len3_last_on_beat", last_idx[0], 3);
        check("len3_done_count", done_cnt[0], 1);
        check("len3_done_cycle", done_cyc[0] - first_req[0], 5);
        check("len3_ready_return", ready_rise[0] - first_req[0], 6);

        // len=0 is one beat
        clear_tally();
        jv[0] = 1'b1; jl[0] = 4'd0;
        tick();
        jv[0] = 1'b0;
        wait_ready(0, 30);
        check("len0_beats", beats[0], 1);
        check("len0_last_on_beat", last_idx[0], 1);
        check("len0_done_count", done_cnt[0], 1);

        // both ports request together
        clear_tally();
        jv = 2'b11; jl[0] = 4'd2; jl[1] = 4'd2;
        tick();
        jv = 2'b00;
        wait_ready(1, 40);
        check("dual_beats0", beats[0], 2);
        check("dual_beats1", beats[1], 2);
        check("dual_done0", done_cnt[0], 1);
        check("dual_done1", done_cnt[1], 1);
        check("dual_port1_after_port0", first_beat[1] - done_cyc[0], 3);

        // forced grant from here on
        use_arb = 1'b0;
        tick();

        // grant lost after beat 2 of len=5
        clear_tally();
        jv[0] = 1'b1; jl[0] = 4'd5;
        tick();
        jv[0] = 1'b0; gf0 = 1'b1;
        tick();
        tick();
        tick();
        gf0 = 1'b0;
        wait_ready(0, 30);
        check("abort_beats", beats[0], 2);
        check("abort_count", abort_cnt[0], 1);
        check("abort_no_done", done_cnt[0], 0);

        // starvation then late grant
        clear_tally();
        jv[0] = 1'b1; jl[0] = 4'd2;
        tick();
        jv[0] = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("starve_req_held", int'(req[0]), 1);
        check("starve_flag", int'(starve[0]), 1);
        check("starve_cycle", first_starve[0] - first_req[0], StarveCyc - 1);
        gf0 = 1'b1;
        wait_ready(0, 30);
        gf0 = 1'b0;
        check("starve_cleared", int'(starve[0]), 0);
        check("starve_beats", beats[0], 2);
        check("starve_done", done_cnt[0], 1);

        // grant arrives on the threshold edge
        clear_tally();
        jv[0] = 1'b1; jl[0] = 4'd1;
        tick();
        jv[0] = 1'b0;
        for (int k = 0; k < StarveCyc - 2; k++) tick();
        gf0 = 1'b1;
        wait_ready(0, 30);
        gf0 = 1'b0;
        check("tie_no_starve", first_starve[0], -1);
        check("tie_beats", beats[0], 1);

        // reset in the middle of a len=4 burst, grant kept high throughout
        clear_tally();
        jv[0] = 1'b1; jl[0] = 4'd4;
        tick();
        jv[0] = 1'b0; gf0 = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_outputs_zero",
              int'({ready[0], req[0], bv[0], last[0], done[0], abort[0], starve[0]}), 0);
        tick();
        rst_n = 1'b1;
        clear_tally();
        for (int k = 0; k < 6; k++) tick();
        gf0 = 1'b0;
        check("reset_no_done", done_cnt[0], 0);
        check("reset_no_abort", abort_cnt[0], 0);
        check("reset_no_beats", beats[0], 0);
        check("reset_idle_ready", int'(ready[0]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
# arb_requester

Client-side agent for the two-port req/gnt arbiter: it accepts a transfer job, raises `req`, waits for `gnt`, then drives a burst of beats on the shared resource while it holds the grant. It releases `req` and enforces an idle gap before the next job. One instance sits on each arbiter port (req_0/gnt_0, req_1/gnt_1), for example in front of the shared UART transmitter.

## Interface
- `LEN_W`, default 4: width of the job length field, in beats.
- `GAP_CYC`, default 1: number of cycles `req` is held low after each job (minimum 1).
- `STARVE_CYC`, default 15: number of REQ-state cycles without `gnt` before `starve` is flagged.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; all state clears immediately while low.
- `job_valid`  in  1  a job is offered.
- `job_len`  in  LEN_W  beat count of the offered job; 0 is treated as 1.
- `job_ready`  out  1  the block can accept a job (IDLE state only).
- `req`  out  1  request to the arbiter.
- `gnt`  in  1  grant from the arbiter.
- `beat_valid`  out  1  drives the shared resource this cycle.
- `beat_last`  out  1  final beat of the current job.
- `done`  out  1  one-cycle pulse: the job completed all beats.
- `abort`  out  1  one-cycle pulse: the grant was lost mid-burst.
- `starve`  out  1  sticky flag: waited STARVE_CYC cycles; cleared on the next `gnt`.

## Operation
- States are IDLE, REQ, XFER, GAP; reset enters IDLE.
- IDLE:
  - `job_ready`=1.
  - `job_valid` sampled high latches `job_len` into the beat counter, going to REQ.
- REQ:
  - `req`=1 and the wait counter increments.
  - `gnt`=1 goes to XFER and clears `starve`.
  - The wait counter reaching STARVE_CYC sets `starve`. The block keeps requesting; there is no timeout exit.
- XFER:
  - `req`=1, `beat_valid`=`gnt`, and the counter decrements per beat.
  - `beat_last`=1 when the remaining count is 1.
  - After the last beat, `done` pulses and the state goes to GAP.
- Grant loss: `gnt`=0 in any XFER cycle means `beat_valid`=0 that cycle, `abort` pulses, and the state goes to GAP. The remaining beats are discarded.
- GAP:
  - `req`=0 for GAP_CYC cycles, then IDLE.
  - New jobs are not accepted during GAP.
- Counter widths:
  - Beat counter is LEN_W bits.
  - Wait counter is wide enough for STARVE_CYC and saturates (no wrap).
- All outputs are registered except `beat_valid`, which is `gnt` qualified by the XFER state.

## Timing
- Reset values: `job_ready`=0 while `reset` is low and 1 in the first cycle after release. `req`, `beat_valid`, `beat_last`, `done`, `abort`, `starve` are all 0.
- Job accepted at edge N: `req`=1 from cycle N+1.
- `gnt` seen at edge M: first beat in cycle M+1.
- Job of L beats with continuous grant: beats in cycles M+1..M+L, `done` in cycle M+L+1 together with `req`=0.
- `req` is low for exactly GAP_CYC cycles. The next `job_ready`=1 is in cycle M+L+1+GAP_CYC.
- Simultaneous `gnt` and starve threshold in the same cycle: `gnt` wins and `starve` stays 0.
- `gnt`=1 while in IDLE or GAP is ignored.
- Reset asserted mid-XFER: all outputs go to 0 asynchronously. No `done` or `abort` is emitted after release.

## Structure
- Shared package/header holds the state encoding constants (IDLE=2'd0, REQ=2'd1, XFER=2'd2, GAP=2'd3) and default parameter values.
- Single module, no sub-modules. Counters are inline.
- The top-level bench pairs two instances with the arbiter (clock, reset, req_0/1, gnt_0/1).

## Test plan
- Single job, len=3, arbiter idle: `req` rises the cycle after accept; 3 beats with `beat_last` on the 3rd; `done` pulses once; `req` low for 1 cycle; `job_ready` returns.
- len=0: exactly 1 beat with `beat_last`=1, then `done`.
- Two instances request in the same cycle: the arbiter's priority port finishes its beats and `done`, then the other port is granted. Beat bursts never overlap.
- `gnt` forced low after beat 2 of a len=5 job: no beat 3; `abort` pulses once; `done` stays 0; GAP then IDLE.
- `gnt` withheld for 20 cycles: `starve`=1 from the 15th REQ cycle and `req` stays 1. `gnt` then rises, `starve` clears, and the burst completes.
- `reset` pulled low in the middle of a len=4 burst: all outputs go to 0 immediately. After release the block is in IDLE with `job_ready`=1, and no stale `done` appears.
